// File: rtl/wf68k30l_dr_writeback_ctrl.sv
// -----------------------------------------------------------------------------
// wf68k30l_dr_writeback_ctrl
//
// Writeback sequencer on the write side of the data register file.
//
// The block handles one outstanding writeback at a time:
//   1. It accepts an op from the control unit.
//   2. It marks the destination register(s) as in use in the register file.
//   3. It waits for the execution result.
//   4. It drives the write strobes for exactly one cycle.
//   5. It issues UNMARK for one cycle, then returns to IDLE.
//
// Ports
//   CLK, RESET_N        clock, asynchronous active-low reset
//   ISSUE_*             op handshake from the control unit
//                       (destination registers, pair flag, operand size)
//   RES_*               result handshake from the execution unit
//   FLUSH               abandon the outstanding op (exception)
//   DR_IN_USE           register-file hazard flag; blocks a new issue
//   DR_MARK_USED, DR_SEL_WR_1/2, USE_DPAIR
//                       mark request to the register file
//   DR_WR_1/2, DR_IN_1/2, OP_SIZE
//                       write port to the register file
//   UNMARK              clears the register-file marks
//   BUSY                sequencer is not in IDLE
//   WB_TIMEOUT          one-cycle pulse when an op is abandoned by timeout
//
// The operand size encoding is shared through wf68k30l_dr_wb_pkg.
// -----------------------------------------------------------------------------
package wf68k30l_dr_wb_pkg;
  typedef enum logic [1:0] {
    LONG = 2'b00,
    WORD = 2'b01,
    BYTE = 2'b10
  } op_size_t;
endpackage

module wf68k30l_dr_writeback_ctrl
  import wf68k30l_dr_wb_pkg::*;
#(
  // WAIT_RES cycles without a result before the op is abandoned (>= 2).
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        ISSUE_VALID,
  output logic        ISSUE_READY,
  input  logic [2:0]  ISSUE_DST_1,
  input  logic [2:0]  ISSUE_DST_2,
  input  logic        ISSUE_PAIR,
  input  logic [1:0]  ISSUE_SIZE,
  input  logic        RES_VALID,
  output logic        RES_READY,
  input  logic [31:0] RES_DATA_1,
  input  logic [31:0] RES_DATA_2,
  input  logic        FLUSH,
  input  logic        DR_IN_USE,
  output logic        DR_MARK_USED,
  output logic [2:0]  DR_SEL_WR_1,
  output logic [2:0]  DR_SEL_WR_2,
  output logic        USE_DPAIR,
  output logic        DR_WR_1,
  output logic        DR_WR_2,
  output logic [31:0] DR_IN_1,
  output logic [31:0] DR_IN_2,
  output logic [1:0]  OP_SIZE,
  output logic        UNMARK,
  output logic        BUSY,
  output logic        WB_TIMEOUT
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RES,
    WRITE,
    RELEASE
  } state_t;

  state_t          state;
  logic [2:0]      dst1_q;
  logic [2:0]      dst2_q;
  logic            pair_q;
  op_size_t        size_q;
  logic [31:0]     data1_q;
  logic [31:0]     data2_q;
  logic [CW-1:0]   cnt;

  logic accept;

  // ISSUE_READY is gated by RESET_N so that it reads 0 while reset is
  // asserted, not only after the first clock edge.
  assign ISSUE_READY = RESET_N && (state == IDLE) && !DR_IN_USE;
  assign accept      = ISSUE_VALID && ISSUE_READY;

  // The mark request is combinational. The register file latches the
  // select lines on the same edge that moves this block into WAIT_RES.
  assign DR_MARK_USED = accept;
  assign USE_DPAIR    = accept && ISSUE_PAIR;
  assign DR_SEL_WR_1  = accept ? ISSUE_DST_1 : dst1_q;
  assign DR_SEL_WR_2  = accept ? ISSUE_DST_2 : dst2_q;

  // FLUSH outranks a result. A timeout pulse is raised only when neither
  // a flush nor a result arrives in the final allowed WAIT_RES cycle.
  assign RES_READY  = (state == WAIT_RES);
  assign WB_TIMEOUT = RES_READY && !FLUSH && !RES_VALID && (cnt == LAST_CNT);

  // Write port outputs. The data registers only load on result capture,
  // so DR_IN_1/2 keep their last values outside WRITE.
  assign DR_WR_1 = (state == WRITE);
  assign DR_WR_2 = (state == WRITE) && pair_q;
  assign DR_IN_1 = data1_q;
  assign DR_IN_2 = data2_q;
  assign OP_SIZE = size_q;
  assign UNMARK  = (state == RELEASE);
  assign BUSY    = (state != IDLE);

  // NOTE: state and datapath registers use non-blocking assignments so
  // that every register samples values from before the clock edge.
  // NOTE: the datapath registers are reset along with the state because
  // they drive outputs directly, and every output must read zero in reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      dst1_q  <= '0;
      dst2_q  <= '0;
      pair_q  <= 1'b0;
      size_q  <= LONG;
      data1_q <= '0;
      data2_q <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dst1_q <= ISSUE_DST_1;
            dst2_q <= ISSUE_DST_2;
            pair_q <= ISSUE_PAIR;
            size_q <= op_size_t'(ISSUE_SIZE);
            cnt    <= '0;
            state  <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          cnt <= cnt + CW'(1);
          if (FLUSH) begin
            state <= RELEASE;
          end else if (RES_VALID) begin
            data1_q <= RES_DATA_1;
            data2_q <= RES_DATA_2;
            state   <= WRITE;
          end else if (cnt == LAST_CNT) begin
            state <= RELEASE;
          end
        end
        // A write that has started always completes; FLUSH is ignored here.
        WRITE:   state <= RELEASE;
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wf68k30l_dr_writeback_ctrl.md
Name: wf68k30l_dr_writeback_ctrl

Overview:
- Writeback sequencer on the write side of the data register file.
- Accepts instruction issue from the control unit and marks the destination register(s) in use.
- Collects the execution result, then drives the register-file write strobes and unmarks.
- Sources DR_MARK_USED, DR_SEL_WR_1/2, USE_DPAIR, DR_WR_1/2, DR_IN_1/2, OP_SIZE and UNMARK, and consumes DR_IN_USE. One writeback is outstanding at a time.

Parameters:
TIMEOUT, 64, WAIT_RES cycles without a result before the op is abandoned; must be at least 2.

Ports:
CLK  in  1  clock
RESET_N  in  1  asynchronous active-low reset
ISSUE_VALID  in  1  control unit offers an op
ISSUE_READY  out  1  op may be accepted
ISSUE_DST_1  in  3  primary destination Dn
ISSUE_DST_2  in  3  secondary destination Dn (pair ops)
ISSUE_PAIR  in  1  op writes two registers
ISSUE_SIZE  in  2  operand size, package BYTE/WORD/LONG encoding
RES_VALID  in  1  execution result available
RES_READY  out  1  result may be accepted
RES_DATA_1  in  32  result for DST_1
RES_DATA_2  in  32  result for DST_2
FLUSH  in  1  abandon the outstanding op (exception)
DR_IN_USE  in  1  register-file hazard flag
DR_MARK_USED  out  1  mark strobe to the register file
DR_SEL_WR_1  out  3  write select 1
DR_SEL_WR_2  out  3  write select 2
USE_DPAIR  out  1  second mark valid
DR_WR_1  out  1  write strobe 1
DR_WR_2  out  1  write strobe 2
DR_IN_1  out  32  write data 1
DR_IN_2  out  32  write data 2
OP_SIZE  out  2  write size
UNMARK  out  1  clear marks
BUSY  out  1  state is not IDLE
WB_TIMEOUT  out  1  one-cycle pulse when an op is abandoned by timeout

Behaviour:
- States: IDLE, WAIT_RES, WRITE, RELEASE. Async reset forces IDLE, clears all registers and zeroes every output. ISSUE_READY is 0 while RESET_N is low.
- IDLE:
  - ISSUE_READY = !DR_IN_USE.
  - On ISSUE_VALID && ISSUE_READY:
    - Assert DR_MARK_USED combinationally that cycle.
    - DR_SEL_WR_1/2 = ISSUE_DST_1/2; USE_DPAIR = ISSUE_PAIR (register file latches at the edge).
    - Latch DST, PAIR and SIZE; clear the timeout counter; go to WAIT_RES.
  - Otherwise DR_SEL_WR_1/2 hold their last latched values.
- WAIT_RES:
  - RES_READY = 1; the counter increments every cycle.
  - On RES_VALID: capture RES_DATA_1/2 and go to WRITE.
  - FLUSH has priority over RES_VALID: go to RELEASE without writing.
  - If the counter reaches TIMEOUT-1 with no result: pulse WB_TIMEOUT and go to RELEASE.
- WRITE (exactly 1 cycle):
  - DR_WR_1 = 1; DR_WR_2 = latched PAIR.
  - DR_IN_1/2 = captured data; OP_SIZE = latched SIZE.
  - FLUSH is ignored here: the write completes. Next state RELEASE.
- RELEASE (1 cycle): UNMARK = 1, then go to IDLE.
- Latency: result accepted at edge N; register file updated at N+1; marks cleared at N+2; ISSUE_READY may assert in cycle N+3.
- Outside WRITE: DR_WR_1/2 = 0 and DR_IN_1/2 hold their last values. DR_MARK_USED and UNMARK are never asserted in the same cycle.
- PAIR with DST_1 == DST_2: both strobes are asserted and port 2 data wins (register-file ordering). The block does not detect this case.
- PAIR with SIZE != LONG: both ports are written at that size, no error.
- ISSUE_VALID is ignored outside IDLE. RES_VALID is ignored outside WAIT_RES (RES_READY = 0).
- Reset mid-operation: immediate IDLE, no write or UNMARK is issued. The register file's own reset clears its marks.

Test Plan:
- Reset release, issue DST_1=3, SIZE=LONG, PAIR=0; result 0xDEADBEEF two cycles later -> DR_MARK_USED pulses at issue; DR_WR_1=1 with DR_IN_1=0xDEADBEEF, OP_SIZE=LONG one cycle after the result; UNMARK next cycle; ISSUE_READY re-asserts the cycle after that.
- Pair issue DST_1=0, DST_2=1 (LONG), results 0x11111111/0x22222222 -> USE_DPAIR=1 at mark; DR_WR_1 and DR_WR_2 both asserted in the same cycle with matching data.
- DR_IN_USE=1 in IDLE with ISSUE_VALID=1 -> ISSUE_READY=0, no DR_MARK_USED; drop DR_IN_USE -> issue accepted that cycle.
- FLUSH and RES_VALID in the same WAIT_RES cycle -> no DR_WR_*, UNMARK next cycle, back to IDLE; FLUSH during WRITE -> write still occurs.
- TIMEOUT=4, no result -> WB_TIMEOUT pulses on the 4th WAIT_RES cycle, then UNMARK, IDLE, no writes.
- RESET_N low while in WAIT_RES -> outputs zero immediately (asynchronously); after release BUSY=0 and a new issue is accepted normally.
